// File: rtl/joystick_merge_n.sv
// joystick_merge_n: synchronises two active-low joystick sources, merges them (press wins), debounces per bit, and can add autofire on fire1.
// Autofire is compiled in only when JOY_AUTOFIRE_EN is defined; with DEBOUNCE_TICKS=0 a src edge reaches joy_out after 3 clk.
module joystick_merge_n #(
    parameter int PORTS          = 4,
    parameter int BITS           = 6,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int AUTOFIRE_TICKS = 50000,
    parameter int REVERSE_DIRS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena_1mhz,
    input  logic [PORTS*BITS-1:0] src_a,
    input  logic [PORTS*BITS-1:0] src_b,
    input  logic [PORTS-1:0]      autofire_en,
    output logic [PORTS*BITS-1:0] joy_out,
    output logic [PORTS-1:0]      activity
);
    localparam int W = PORTS * BITS;

    logic [W-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [W-1:0] raw;
    logic [W-1:0] deb_q, deb_d;
    logic [W-1:0] joy_q, joy_d;
    logic [PORTS-1:0] act_q, act_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1_q <= '1;
            a_s2_q <= '1;
            b_s1_q <= '1;
            b_s2_q <= '1;
        end else begin
            a_s1_q <= src_a;
            a_s2_q <= a_s1_q;
            b_s1_q <= src_b;
            b_s2_q <= b_s1_q;
        end
    end

    // Reversal mirrors each axis: right<->left and down<->up.
    function automatic logic [W-1:0] reorder(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        if (REVERSE_DIRS != 0) begin
            for (int p = 0; p < PORTS; p++) begin
                r[p*BITS+0] = v[p*BITS+1];
                r[p*BITS+1] = v[p*BITS+0];
                r[p*BITS+2] = v[p*BITS+3];
                r[p*BITS+3] = v[p*BITS+2];
            end
        end
        return r;
    endfunction

    assign raw = reorder(a_s2_q) & reorder(b_s2_q);

    generate
        if (DEBOUNCE_TICKS == 0) begin : g_nodeb
            assign deb_d = raw;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
            localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_TICKS);
            logic [CW-1:0] cnt_q [W];
            logic [CW-1:0] cnt_d [W];

            always_comb begin
                deb_d = deb_q;
                for (int i = 0; i < W; i++) begin
                    cnt_d[i] = cnt_q[i];
                    if (raw[i] == deb_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (ena_1mhz) begin
                        // The tick that brings the count to DEBOUNCE_TICKS commits the bit.
                        if (cnt_q[i] >= CMAX - 1'b1) begin
                            deb_d[i] = raw[i];
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < W; i++) begin
                    if (reset) cnt_q[i] <= '0;
                    else       cnt_q[i] <= cnt_d[i];
                end
            end
        end
    endgenerate

`ifdef JOY_AUTOFIRE_EN
    localparam logic [15:0] AF_LAST = 16'(AUTOFIRE_TICKS - 1);
    logic [15:0] af_q, af_d;
    logic        phase_q, phase_d;

    always_comb begin
        af_d    = af_q;
        phase_d = phase_q;
        if (ena_1mhz) begin
            if (af_q == AF_LAST) begin
                af_d    = '0;
                phase_d = ~phase_q;
            end else begin
                af_d = af_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            af_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            af_q    <= af_d;
            phase_q <= phase_d;
        end
    end
`else
    logic unused_af;
    assign unused_af = ^{autofire_en, ena_1mhz, 16'(AUTOFIRE_TICKS)};
`endif

    // Output is computed from next-state so joy_out stays registered without adding a stage.
    always_comb begin
        joy_d = deb_d;
        act_d = '0;
        for (int p = 0; p < PORTS; p++) begin
            act_d[p] = |(deb_d[p*BITS +: BITS] ^ deb_q[p*BITS +: BITS]);
`ifdef JOY_AUTOFIRE_EN
            if (autofire_en[p] && !deb_d[p*BITS+4]) joy_d[p*BITS+4] = phase_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= '1;
            joy_q <= '1;
            act_q <= '0;
        end else begin
            deb_q <= deb_d;
            joy_q <= joy_d;
            act_q <= act_d;
        end
    end

    assign joy_out  = joy_q;
    assign activity = act_q;
endmodule

// File: tb/tb_joystick_merge_n.sv
// Scoreboard bench: stimulus queues expected activity events, per-DUT monitors pop and compare joy_out, activity and cycle.
`timescale 1ns/1ps
module tb_joystick_merge_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ena;
    logic [11:0] a0, b0, joy0;
    logic [1:0]  af0, act0;
    logic [23:0] a1, b1, joy1;
    logic [3:0]  af1, act1;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [23:0] joy;
        logic [3:0]  act;
        int          cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    joystick_merge_n #(.PORTS(2), .BITS(6), .DEBOUNCE_TICKS(0), .AUTOFIRE_TICKS(4), .REVERSE_DIRS(1)) dut0 (
        .clk(clk), .reset(reset), .ena_1mhz(ena), .src_a(a0), .src_b(b0),
        .autofire_en(af0), .joy_out(joy0), .activity(act0)
    );

    joystick_merge_n #(.PORTS(4), .BITS(6), .DEBOUNCE_TICKS(16), .AUTOFIRE_TICKS(4), .REVERSE_DIRS(1)) dut1 (
        .clk(clk), .reset(reset), .ena_1mhz(ena), .src_a(a1), .src_b(b1),
        .autofire_en(af1), .joy_out(joy1), .activity(act1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Tick is seen by the edges that make cyc a multiple of 4.
    initial begin
        ena = 1'b0;
        forever begin
            @(negedge clk);
            ena = (cyc % 4 == 3);
        end
    end

    always @(negedge clk) begin
        if (mon_en && act0 !== 2'b00) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected_event: activity=%b joy=%h cyc=%0d", act0, joy0, cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (joy0 !== e.joy[11:0] || act0 !== e.act[1:0] || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL dut0_event: got joy=%h act=%b cyc=%0d, expected joy=%h act=%b cyc=%0d",
                             joy0, act0, cyc, e.joy[11:0], e.act[1:0], e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && act1 !== 4'b0000) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_event: activity=%b joy=%h cyc=%0d", act1, joy1, cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (joy1 !== e.joy || act1 !== e.act || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL dut1_event: got joy=%h act=%b cyc=%0d, expected joy=%h act=%b cyc=%0d",
                             joy1, act1, cyc, e.joy, e.act, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        do @(negedge clk); while (cyc % 4 != 0);
    endtask

    task automatic push0(input logic [11:0] j, input logic [1:0] a, input int lat);
        exp_t e;
        e.joy = {12'h000, j};
        e.act = {2'b00, a};
        e.cyc = cyc + lat;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [23:0] j, input logic [3:0] a, input int lat);
        exp_t e;
        e.joy = j;
        e.act = a;
        e.cyc = cyc + lat;
        q1.push_back(e);
    endtask

    initial begin
        logic prev;
        int   run;
        reset = 1'b1;
        a0 = '1; b0 = '1; af0 = '0;
        a1 = '1; b1 = '1; af1 = '0;
        step(4);
        check("rst_joy0", 32'(joy0), 32'h0000_0FFF);
        check("rst_act0", 32'(act0), 32'h0);
        check("rst_joy1", 32'(joy1), 32'h00FF_FFFF);
        check("rst_act1", 32'(act1), 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        step(2);

        // No debounce: port1 right lands on port1 left (bit 7) after 3 clk.
        push0(12'hF7F, 2'b10, 3);
        a0[6] = 1'b0;
        step(6);
        check("nodeb_hold", 32'(joy0), 32'h0000_0F7F);
        push0(12'hFFF, 2'b10, 3);
        a0[6] = 1'b1;
        step(6);

        // B presses port0 up (shows as down, bit 2); then A press with B release keeps it pressed.
        push0(12'hFFB, 2'b01, 3);
        b0[3] = 1'b0;
        step(6);
        a0[3] = 1'b0;
        b0[3] = 1'b1;
        step(6);
        check("press_wins", 32'(joy0), 32'h0000_0FFB);
        push0(12'hFFF, 2'b01, 3);
        a0[3] = 1'b1;
        step(6);

        // Bounce fire2 of port 2 for 10 ticks; only the final steady low is accepted.
        align();
        for (int i = 0; i < 10; i++) begin
            a1[17] = (i % 2 == 1);
            step(4);
        end
        check("bounce_no_change", 32'(joy1), 32'h00FF_FFFF);
        push1(24'hFDFFFF, 4'b0100, 64);
        a1[17] = 1'b0;
        step(62);
        check("deb_not_early", 32'(joy1), 32'h00FF_FFFF);
        step(8);
        check("deb_done", 32'(joy1), 32'h00FD_FFFF);
        align();
        push1(24'hFFFFFF, 4'b0100, 64);
        a1[17] = 1'b1;
        step(70);

        // Fire1 of port 0 from A only.
        align();
        push1(24'hFFFFEF, 4'b0001, 64);
        a1[4] = 1'b0;
        step(70);
        check("fire_a_only", 32'(joy1), 32'h00FF_FFEF);

        af1 = 4'hF;
`ifdef JOY_AUTOFIRE_EN
        align();
        prev = joy1[4];
        run = 0;
        do begin align(); run++; end while (joy1[4] == prev && run < 12);
        check("af_toggles", 32'(joy1[4] != prev), 32'h1);
        for (int k = 0; k < 3; k++) begin
            prev = joy1[4];
            run = 0;
            do begin align(); run++; end while (joy1[4] == prev && run < 12);
            check("af_half_period", 32'(run), 32'd4);
        end
`else
        for (int k = 0; k < 40; k++) begin
            step(1);
            check("fire_const_no_af", 32'(joy1[4]), 32'h0);
        end
`endif
        @(negedge clk);
        af1 = 4'h0;
        step(1);
        check("af_off_next_clk", 32'(joy1[4]), 32'h0);
        align();
        push1(24'hFFFFFF, 4'b0001, 64);
        a1[4] = 1'b1;
        step(70);

        // Reset at tick 8 of a debounce: a fresh 16 ticks are needed afterwards.
        align();
        a1[23] = 1'b0;
        step(34);
        reset = 1'b1;
        step(1);
        check("midrst_joy1", 32'(joy1), 32'h00FF_FFFF);
        check("midrst_act1", 32'(act1), 32'h0);
        step(1);
        reset = 1'b0;
        push1(24'h7FFFFF, 4'b1000, 64);
        step(62);
        check("postrst_not_early", 32'(joy1), 32'h00FF_FFFF);
        step(8);
        check("postrst_done", 32'(joy1), 32'h007F_FFFF);
        align();
        push1(24'hFFFFFF, 4'b1000, 64);
        a1[23] = 1'b1;
        step(70);

        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
